// File: rtl/match_score_controller_pkg.sv
// Shared types and constants for the match score controller.
package match_score_controller_pkg;

  localparam int SCORE_W        = 7;
  localparam int WIN_POINTS_DEF = 11;
  localparam int WIN_MARGIN_DEF = 2;
  localparam int MAX_SCORE_DEF  = 99;

  typedef enum logic {
    ST_PLAY      = 1'b0,
    ST_GAME_OVER = 1'b1
  } state_t;

  // Lead is taken in 8-bit signed so a trailing player never wraps to a huge lead.
  function automatic logic has_won(input logic [SCORE_W-1:0] me,
                                   input logic [SCORE_W-1:0] other,
                                   input logic [SCORE_W-1:0] win_pts,
                                   input logic [SCORE_W-1:0] max_sc,
                                   input logic signed [7:0]  margin);
    logic signed [7:0] lead;
    lead    = $signed({1'b0, me}) - $signed({1'b0, other});
    has_won = (me >= win_pts || me == max_sc) &&
              (lead >= margin || (me == max_sc && lead > 8'sd0));
  endfunction

endpackage

// File: rtl/match_score_controller_display_alternator.sv
// Alternates the displayed player every SHOW_MS cycles; in GAME_OVER shows the winner and blinks.
module match_score_controller_display_alternator
  import match_score_controller_pkg::*;
#(
  parameter int SHOW_MS  = 1000,
  parameter int BLINK_MS = 250
) (
  input  logic               clk,
  input  logic               rst,
  input  state_t             state,
  input  logic               winner,
  input  logic [SCORE_W-1:0] score_p1,
  input  logic [SCORE_W-1:0] score_p2,
  output logic [SCORE_W-1:0] disp_value,
  output logic               disp_player,
  output logic               disp_blank
);

  localparam int SHOW_W  = (SHOW_MS  > 1) ? $clog2(SHOW_MS)  : 1;
  localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  logic [SHOW_W-1:0]  show_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               sel_q;
  logic               blank_q;
  logic               over;

  assign over        = (state == ST_GAME_OVER);
  assign disp_player = over ? winner : sel_q;
  assign disp_blank  = over & blank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      show_cnt   <= '0;
      sel_q      <= 1'b0;
      disp_value <= '0;
    end else begin
      if (show_cnt == SHOW_LAST) begin
        show_cnt <= '0;
        sel_q    <= ~sel_q;
      end else begin
        show_cnt <= show_cnt + 1'b1;
      end
      disp_value <= disp_player ? score_p2 : score_p1;
    end
  end

  // Blink phase is held at zero throughout PLAY so each game-over starts unblanked.
  always_ff @(posedge clk) begin
    if (rst || !over) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blank_q   <= ~blank_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/match_score_controller.sv
// Two-player score keeping, win detection and display routing for a 1 kHz scoreboard.
module match_score_controller
  import match_score_controller_pkg::*;
#(
  parameter int WIN_POINTS = WIN_POINTS_DEF,
  parameter int WIN_MARGIN = WIN_MARGIN_DEF,
  parameter int MAX_SCORE  = MAX_SCORE_DEF,
  parameter int SHOW_MS    = 1000,
  parameter int BLINK_MS   = 250
) (
  input  logic               clk_1khz_i,
  input  logic               rst_i,
  input  logic               p1_short_i,
  input  logic               p1_long_i,
  input  logic               p2_short_i,
  input  logic               p2_long_i,
  output logic [SCORE_W-1:0] score_p1_o,
  output logic [SCORE_W-1:0] score_p2_o,
  output logic [SCORE_W-1:0] disp_value_o,
  output logic               disp_player_o,
  output logic               disp_blank_o,
  output logic               winner_valid_o,
  output logic               winner_o
);

  localparam logic [SCORE_W-1:0] WP = SCORE_W'(WIN_POINTS);
  localparam logic [SCORE_W-1:0] MX = SCORE_W'(MAX_SCORE);
  localparam logic signed [7:0]  MG = 8'(WIN_MARGIN);

  state_t             state;
  logic [SCORE_W-1:0] s1_n, s2_n;
  logic               p1_win, p2_win;

  always_comb begin
    s1_n = score_p1_o;
    s2_n = score_p2_o;
    if (p1_long_i && p2_long_i) begin
      s1_n = '0;
      s2_n = '0;
    end else begin
      if (p1_short_i && !p1_long_i && score_p1_o < MX)       s1_n = score_p1_o + 1'b1;
      else if (p1_long_i && !p1_short_i && score_p1_o != '0) s1_n = score_p1_o - 1'b1;
      if (p2_short_i && !p2_long_i && score_p2_o < MX)       s2_n = score_p2_o + 1'b1;
      else if (p2_long_i && !p2_short_i && score_p2_o != '0) s2_n = score_p2_o - 1'b1;
    end
    p1_win = has_won(s1_n, s2_n, WP, MX, MG);
    p2_win = has_won(s2_n, s1_n, WP, MX, MG);
  end

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      state          <= ST_PLAY;
      score_p1_o     <= '0;
      score_p2_o     <= '0;
      winner_valid_o <= 1'b0;
      winner_o       <= 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          score_p1_o <= s1_n;
          score_p2_o <= s2_n;
          if (p1_win || p2_win) begin
            state          <= ST_GAME_OVER;
            winner_valid_o <= 1'b1;
            winner_o       <= p2_win;
          end
        end
        ST_GAME_OVER: begin
          if (p1_long_i || p2_long_i) begin
            state          <= ST_PLAY;
            score_p1_o     <= '0;
            score_p2_o     <= '0;
            winner_valid_o <= 1'b0;
            winner_o       <= 1'b0;
          end
        end
        default: state <= ST_PLAY;
      endcase
    end
  end

  match_score_controller_display_alternator #(
    .SHOW_MS  (SHOW_MS),
    .BLINK_MS (BLINK_MS)
  ) u_display_alternator (
    .clk         (clk_1khz_i),
    .rst         (rst_i),
    .state       (state),
    .winner      (winner_o),
    .score_p1    (score_p1_o),
    .score_p2    (score_p2_o),
    .disp_value  (disp_value_o),
    .disp_player (disp_player_o),
    .disp_blank  (disp_blank_o)
  );

endmodule

// File: tb/tb_match_score_controller.sv
// Randomized scoreboard bench for match_score_controller against a plain integer game model.
module tb_match_score_controller;

  localparam int WP = 11, WM = 2, MX = 99, SHOW = 1000, BLINK = 250;

  logic clk = 1'b0, rst = 1'b1;
  logic p1s = 1'b0, p1l = 1'b0, p2s = 1'b0, p2l = 1'b0;
  logic [6:0] s1o, s2o, dvo;
  logic dpo, dbo, wvo, wo;

  typedef struct {
    int s1, s2, val;
    bit player, blank, wv, w;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   started = 0, done = 0;

  int   m_s1 = 0, m_s2 = 0, t = 0, t_win = 0;
  bit   over = 0, win_p2 = 0;
  exp_t prev = '{default: 0};

  always #5 clk = ~clk;

  match_score_controller dut (
    .clk_1khz_i     (clk),
    .rst_i          (rst),
    .p1_short_i     (p1s),
    .p1_long_i      (p1l),
    .p2_short_i     (p2s),
    .p2_long_i      (p2l),
    .score_p1_o     (s1o),
    .score_p2_o     (s2o),
    .disp_value_o   (dvo),
    .disp_player_o  (dpo),
    .disp_blank_o   (dbo),
    .winner_valid_o (wvo),
    .winner_o       (wo)
  );

  function automatic int bump(int s, bit sh, bit lg);
    if (sh && !lg) return (s < MX) ? s + 1 : MX;
    if (lg && !sh) return (s > 0) ? s - 1 : 0;
    return s;
  endfunction

  function automatic bit wins(int me, int oth);
    return (me >= WP || me == MX) && (me - oth >= WM || (me == MX && me > oth));
  endfunction

  // One clock of stimulus; the model predicts what the outputs show after the next edge.
  task automatic cyc(bit r, bit a, bit b, bit c, bit d);
    exp_t e;
    @(negedge clk);
    rst = r; p1s = a; p1l = b; p2s = c; p2l = d;
    if (r) begin
      m_s1 = 0; m_s2 = 0; t = 0; over = 0; win_p2 = 0;
    end else begin
      t++;
      if (over) begin
        if (b || d) begin m_s1 = 0; m_s2 = 0; over = 0; win_p2 = 0; end
      end else if (b && d) begin
        m_s1 = 0; m_s2 = 0;
      end else begin
        m_s1 = bump(m_s1, a, b);
        m_s2 = bump(m_s2, c, d);
        if (wins(m_s1, m_s2))      begin over = 1; win_p2 = 0; t_win = t; end
        else if (wins(m_s2, m_s1)) begin over = 1; win_p2 = 1; t_win = t; end
      end
    end
    e.s1     = m_s1;
    e.s2     = m_s2;
    e.wv     = over;
    e.w      = win_p2;
    e.player = over ? win_p2 : ((t / SHOW) % 2 == 1);
    e.blank  = over ? (((t - t_win) / BLINK) % 2 == 1) : 1'b0;
    e.val    = r ? 0 : (prev.player ? prev.s2 : prev.s1);
    prev = e;
    q.push_back(e);
    started = 1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (s1o !== 7'(e.s1) || s2o !== 7'(e.s2) || dvo !== 7'(e.val) ||
            dpo !== e.player || dbo !== e.blank || wvo !== e.wv ||
            (e.wv && wo !== e.w)) begin
          n_bad++;
          $display("FAIL outputs @%0t: act s=%0d:%0d val=%0d pl=%b bl=%b wv=%b w=%b exp s=%0d:%0d val=%0d pl=%b bl=%b wv=%b w=%b",
                   $time, s1o, s2o, dvo, dpo, dbo, wvo, wo,
                   e.s1, e.s2, e.val, e.player, e.blank, e.wv, e.w);
        end
      end else if (started && !done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expectation @%0t: act s=%0d:%0d exp queued record", $time, s1o, s2o);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] b;
    repeat (3) cyc(1, 0, 0, 0, 0);

    // Player 1 wins 11:0, then blink is observed through GAME_OVER
    repeat (11) begin cyc(0, 1, 0, 0, 0); idle(499); end
    idle(300);
    cyc(0, 0, 0, 1, 0); idle(3);
    cyc(0, 0, 0, 0, 1); idle(2);

    // 10:10 deuce, 11:10 no win, 12:10 win
    repeat (10) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0); idle(2);
    cyc(0, 1, 0, 0, 0); idle(5);
    cyc(0, 0, 1, 0, 0); idle(2);

    // Corrections, floor at 0, conflicting press ignored
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0); idle(2);

    // Simultaneous shorts, then double long with a short clears
    cyc(0, 0, 1, 0, 1);
    repeat (6) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 1); idle(2);

    // Display alternation at 3:7
    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 1, 0);
    idle(2500);

    // Reset mid-game at 8:4
    cyc(0, 0, 1, 0, 1);
    repeat (8) cyc(0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0); idle(3);

    // Saturation at 99:99, then correction lets player 2 win via the max rule
    repeat (99) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0); idle(2);
    cyc(0, 0, 1, 0, 0); idle(5);
    cyc(0, 1, 0, 0, 0); idle(2);
    cyc(0, 0, 1, 0, 0); idle(2);

    // Random play with sparse presses and rare resets
    repeat (15000) begin
      if ($urandom_range(0, 99) < 12) begin
        b[0] = $urandom_range(0, 1) == 1;
        b[1] = $urandom_range(0, 5) == 0;
        b[2] = $urandom_range(0, 1) == 1;
        b[3] = $urandom_range(0, 5) == 0;
        cyc(0, b[0], b[1], b[2], b[3]);
      end else if ($urandom_range(0, 4999) == 0) begin
        cyc(1, 0, 0, 0, 0);
      end else begin
        idle(1);
      end
    end

    @(posedge clk);
    #3;
    done = 1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d records left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
